wb_bridge_master_if: RTL and testbench



---
 rtl/wb_bridge_master_if.sv | 147 ++++++++++++++
 tb/tb_wb_bridge_master_if.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_bridge_master_if.sv
// wb_bridge_master_if
//   Adapts a Wishbone classic master onto the master-side tx/rx pair of the
//   two-flop 4-phase clock-domain bridge. One Wishbone single cycle becomes
//   one request word (vi pulse to tx). The block waits for tx delivery (snt),
//   then for the response word (vo), and ends the cycle with ack or err.
//   Only one transaction is outstanding. A timeout keeps a dead link from
//   hanging the bus.
// Ports
//   clk, reset            : master clock; asynchronous active-low reset
//   wb_cyc_i / wb_stb_i   : Wishbone cycle / strobe
//   wb_we_i, wb_adr_i,    : write enable, address, write data
//   wb_dat_i
//   wb_dat_o              : registered read data, held between transactions
//   wb_ack_o / wb_err_o   : one-cycle termination pulses
//   sdata / vi            : request word and its one-cycle valid to tx
//   snt                   : tx delivered-request pulse
//   rdata / vo            : response word and its valid pulse from rx
module wb_bridge_master_if #(
  parameter int unsigned DATA_MSB = 32,
  parameter int unsigned ADR_W    = 16,
  parameter int unsigned DAT_W    = 16,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned TO_W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [ADR_W-1:0]    wb_adr_i,
  input  logic [DAT_W-1:0]    wb_dat_i,
  output logic [DAT_W-1:0]    wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic [DATA_MSB:0]   sdata,
  output logic                vi,
  input  logic                snt,
  input  logic [DATA_MSB:0]   rdata,
  input  logic                vo
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_SNT, WAIT_RSP, TERM, DRAIN} state_e;

  localparam logic [TO_W:0] TO_LIM = (TO_W+1)'(TIMEOUT);

  state_e              state_q;
  logic [TO_W-1:0]     cnt_q;
  logic [TO_W-1:0]     cnt_d;
  logic [TO_W:0]       cnt_wide;
  logic                to_hit;
  logic                abort_q;
  logic                abort_now;
  logic                rsp_err_q;
  logic                ack_q;
  logic                err_q;
  logic                vi_q;
  logic [DATA_MSB:0]   sdata_q;
  logic [DAT_W-1:0]    dat_q;
  logic                req;
  logic                unused_rdata;

  // Middle response bits carry nothing for the master side.
  assign unused_rdata = ^rdata[DATA_MSB-1:DAT_W];

  always_comb begin
    req       = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    // A cycle dropped in the same clock as the response already counts as aborted.
    abort_now = abort_q | ~wb_cyc_i;
    // One extra bit so the compare cannot wrap when TIMEOUT is near 2^TO_W.
    cnt_wide  = {1'b0, cnt_q} + 1'b1;
    cnt_d     = cnt_wide[TO_W-1:0];
    to_hit    = (cnt_wide >= TO_LIM);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      rsp_err_q <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      vi_q      <= 1'b0;
      sdata_q   <= '0;
      dat_q     <= '0;
    end else begin
      vi_q  <= 1'b0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            sdata_q <= {wb_we_i, wb_adr_i, (wb_we_i ? wb_dat_i : '0)};
            vi_q    <= 1'b1;
            // Counter restarts here so it counts cycles since the vi pulse.
            cnt_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          cnt_q <= cnt_d;
          if (!wb_cyc_i) abort_q <= 1'b1;
          state_q <= WAIT_SNT;
        end
        WAIT_SNT, WAIT_RSP: begin
          cnt_q <= cnt_d;
          if (!wb_cyc_i) abort_q <= 1'b1;
          if (vo && (snt || state_q == WAIT_RSP)) begin
            if (!abort_now) begin
              dat_q     <= rdata[DAT_W-1:0];
              rsp_err_q <= rdata[DATA_MSB];
            end
            state_q <= TERM;
          end else if (to_hit) begin
            err_q   <= ~abort_now;
            abort_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= DRAIN;
          end else if (snt && state_q == WAIT_SNT) begin
            state_q <= WAIT_RSP;
          end
        end
        TERM: begin
          ack_q   <= ~abort_q & ~rsp_err_q;
          err_q   <= ~abort_q & rsp_err_q;
          abort_q <= 1'b0;
          state_q <= IDLE;
        end
        DRAIN: begin
          cnt_q <= cnt_d;
          if (vo || to_hit) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign sdata    = sdata_q;
  assign vi       = vi_q;

endmodule

// File: tb/tb_wb_bridge_master_if.sv
// Bench for wb_bridge_master_if. Instance 0 uses the default timeout,
// instance 1 a short timeout of 8 cycles. Expected outcomes come from a
// transaction-level model: request word packing, termination cycle computed
// from the snt/vo schedule, abort/timeout rules and last-good read data.
module tb_wb_bridge_master_if;

  localparam int T0 = 255;
  localparam int T1 = 8;

  logic        clk;
  logic        reset;
  logic        cyc   [2];
  logic        stb   [2];
  logic        we    [2];
  logic [15:0] adr   [2];
  logic [15:0] dat_i [2];
  logic [15:0] dat_o [2];
  logic        ack   [2];
  logic        err   [2];
  logic [32:0] sdata [2];
  logic        vi    [2];
  logic        snt   [2];
  logic [32:0] rdata [2];
  logic        vo    [2];

  logic [15:0] exp_dat [2];
  int checks   = 0;
  int failures = 0;

  wb_bridge_master_if dut0 (
    .clk(clk), .reset(reset),
    .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
    .wb_adr_i(adr[0]), .wb_dat_i(dat_i[0]), .wb_dat_o(dat_o[0]),
    .wb_ack_o(ack[0]), .wb_err_o(err[0]),
    .sdata(sdata[0]), .vi(vi[0]), .snt(snt[0]), .rdata(rdata[0]), .vo(vo[0])
  );

  wb_bridge_master_if #(.TIMEOUT(T1), .TO_W(8)) dut1 (
    .clk(clk), .reset(reset),
    .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
    .wb_adr_i(adr[1]), .wb_dat_i(dat_i[1]), .wb_dat_o(dat_o[1]),
    .wb_ack_o(ack[1]), .wb_err_o(err[1]),
    .sdata(sdata[1]), .vi(vi[1]), .snt(snt[1]), .rdata(rdata[1]), .vo(vo[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One Wishbone request. sd: cycles from vi to snt; vd: cycles from snt to vo
  // (0 = same cycle); ab >= 0 drops cyc ab cycles after vi; no_vo withholds vo.
  task automatic do_txn(input int s, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input int sd, input int vd,
                        input logic [32:0] rsp, input int ab, input bit no_vo,
                        input string tag);
    int vi_cnt, vi_k, ack_cnt, ack_k, err_cnt, err_k, both;
    int snt_k, vo_k, end_k, to, exp_k;
    bit aborted, exp_ack, exp_err, drop;
    logic [32:0] sd_seen, exp_sd;
    vi_cnt = 0; vi_k = -1; ack_cnt = 0; ack_k = -1; err_cnt = 0; err_k = -1;
    both = 0; drop = 0; sd_seen = '0;
    to      = (s == 0) ? T0 : T1;
    snt_k   = 1 + sd;
    vo_k    = 1 + sd + vd;
    aborted = (ab >= 0);
    exp_sd  = {w, a, (w ? d : 16'h0000)};
    exp_ack = !no_vo && !aborted && !rsp[32];
    exp_err = no_vo ? !aborted : (!aborted && rsp[32]);
    exp_k   = no_vo ? 1 + to : vo_k + 2;
    end_k   = no_vo ? 1 + to + 2 : vo_k + 4;
    for (int k = 0; k <= end_k; k++) begin
      @(posedge clk); #1;
      if (k > 0) begin
        if (vi[s]) begin
          if (vi_cnt == 0) begin vi_k = k; sd_seen = sdata[s]; end
          vi_cnt++;
        end
        if (ack[s]) begin if (ack_cnt == 0) ack_k = k; ack_cnt++; end
        if (err[s]) begin if (err_cnt == 0) err_k = k; err_cnt++; end
        if (ack[s] && err[s]) both++;
        if (ack[s] || err[s]) drop = 1;
      end
      if (aborted && k >= 1 + ab) drop = 1;
      if (k == end_k) drop = 1;
      cyc[s]   = !drop;
      stb[s]   = !drop;
      we[s]    = w;
      adr[s]   = a;
      dat_i[s] = d;
      snt[s]   = (k == snt_k);
      vo[s]    = !no_vo && (k == vo_k);
      rdata[s] = vo[s] ? rsp : {1'($urandom), $urandom};
    end
    snt[s] = 1'b0;
    vo[s]  = 1'b0;
    if (!no_vo && !aborted) exp_dat[s] = rsp[15:0];
    chk({tag, ".vi_count"}, 64'(vi_cnt), 64'(1));
    chk({tag, ".vi_cycle"}, 64'(vi_k), 64'(1));
    chk({tag, ".sdata"}, 64'(sd_seen), 64'(exp_sd));
    chk({tag, ".ack_count"}, 64'(ack_cnt), 64'(exp_ack));
    chk({tag, ".err_count"}, 64'(err_cnt), 64'(exp_err));
    if (exp_ack) chk({tag, ".ack_cycle"}, 64'(ack_k), 64'(exp_k));
    if (exp_err) chk({tag, ".err_cycle"}, 64'(err_k), 64'(exp_k));
    chk({tag, ".ack_and_err"}, 64'(both), 64'(0));
    chk({tag, ".dat_o"}, 64'(dat_o[s]), 64'(exp_dat[s]));
  endtask

  // Idle cycles with an optional stray vo; nothing may terminate or launch.
  task automatic idle_watch(input int s, input int n, input int vo_at,
                            input logic [32:0] rsp, input string tag);
    int act;
    act = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (k > 0 && (ack[s] || err[s] || vi[s])) act++;
      vo[s]    = (k == vo_at);
      rdata[s] = vo[s] ? rsp : {1'($urandom), $urandom};
    end
    vo[s] = 1'b0;
    chk({tag, ".no_activity"}, 64'(act), 64'(0));
    chk({tag, ".dat_o"}, 64'(dat_o[s]), 64'(exp_dat[s]));
  endtask

  initial begin
    int sd, vd, ab;
    logic w;
    logic [15:0] a, d;
    logic [32:0] rsp;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 0; stb[i] = 0; we[i] = 0; adr[i] = '0; dat_i[i] = '0;
      snt[i] = 0; vo[i] = 0; rdata[i] = '0; exp_dat[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset%0d.outputs", i),
          64'({dat_o[i], ack[i], err[i], vi[i], sdata[i]}), 64'(0));
    end
    reset = 1'b1;

    do_txn(0, 1'b0, 16'h1234, 16'hFFFF, 4, 6, 33'h0_0000_BEEF, -1, 0, "read");
    do_txn(0, 1'b1, 16'h00A5, 16'h5A5A, 2, 3, 33'h1_0000_1357, -1, 0, "write_err");
    do_txn(0, 1'b0, 16'h0010, 16'h0000, 3, 0, 33'h0_0000_00FF, -1, 0, "same_cycle");
    idle_watch(0, 5, 2, 33'h1_FFFF_7777, "stray_vo");

    // Reset while the response is outstanding.
    @(posedge clk); #1; cyc[0] = 1; stb[0] = 1; we[0] = 0; adr[0] = 16'h0456;
    @(posedge clk); #1;
    chk("rst.pre_vi", 64'(vi[0]), 64'(1));
    chk("rst.pre_sdata", 64'(sdata[0]), 64'(33'h0_0456_0000));
    @(posedge clk); #1; snt[0] = 1;
    @(posedge clk); #1; snt[0] = 0;
    chk("rst.pre_dat_o", 64'(dat_o[0]), 64'(exp_dat[0]));
    #2 reset = 1'b0;
    #1;
    chk("rst.async_outputs", 64'({dat_o[0], ack[0], err[0], vi[0], sdata[0]}), 64'(0));
    exp_dat[0] = '0;
    exp_dat[1] = '0;
    cyc[0] = 0; stb[0] = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    idle_watch(0, 6, 2, 33'h0_0000_6666, "post_reset_vo");
    do_txn(0, 1'b1, 16'hC0DE, 16'h1234, 1, 1, 33'h0_0000_4321, -1, 0, "fresh");

    do_txn(0, 1'b0, 16'h0001, 16'h0000, 3, 4, 33'h0_0000_1111, 2, 0, "abort");
    do_txn(0, 1'b0, 16'h0002, 16'h0000, 2, 2, 33'h0_0000_2222, -1, 0, "after_abort");

    for (int n = 0; n < 20; n++) begin
      w   = 1'($urandom);
      a   = 16'($urandom);
      d   = 16'($urandom);
      sd  = int'($urandom_range(1, 5));
      vd  = int'($urandom_range(0, 6));
      rsp = {1'($urandom), $urandom};
      ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, sd + vd)) : -1;
      do_txn(0, w, a, d, sd, vd, rsp, ab, 0, $sformatf("rand%0d", n));
    end

    do_txn(1, 1'b0, 16'h0BAD, 16'h0000, 2, 0, 33'h0, -1, 1, "timeout");
    idle_watch(1, 2, 0, 33'h0_0000_9999, "drain_vo");
    do_txn(1, 1'b0, 16'h0CAB, 16'h0000, 1, 2, 33'h0_0000_ACED, -1, 0, "after_timeout");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
